// File: rtl/bp_pkg.sv
// Shared types for the 2-bit branch predictor and its resolve queue.
// The entry layout is fixed by BP_IDX_W/BP_ADDR_W; users of bq_entry_t must match them.
package bp_pkg;

   localparam int BP_IDX_W  = 6;
   localparam int BP_ADDR_W = 32;

   typedef enum logic [1:0] {
      STRONG_NT = 2'b00,
      WEAK_NT   = 2'b01,
      WEAK_T    = 2'b10,
      STRONG_T  = 2'b11
   } ctr_t;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } brq_state_t;

   typedef struct packed {
      logic [BP_IDX_W-1:0]  idx;
      ctr_t                 ctr;
      logic                 taken;
      logic [BP_ADDR_W-1:0] target;
      logic [BP_ADDR_W-1:0] fallthru;
   } bq_entry_t;

   function automatic ctr_t sat_update(input ctr_t ctr, input logic taken);
      ctr_t nxt;
      if (taken)
         nxt = (ctr == STRONG_T) ? STRONG_T : ctr_t'(ctr + 2'd1);
      else
         nxt = (ctr == STRONG_NT) ? STRONG_NT : ctr_t'(ctr - 2'd1);
      return nxt;
   endfunction

endpackage

// File: rtl/bp_fifo.sv
// Circular FIFO of bq_entry_t with flush; DEPTH must be a power of two so pointers wrap naturally.
module bp_fifo
   import bp_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             i_push,
   input  bq_entry_t        i_push_data,
   input  logic             i_pop,
   input  logic             i_flush,
   output bq_entry_t        o_head,
   output logic             o_full,
   output logic             o_empty,
   output logic [CNT_W-1:0] o_count
);

   localparam int PTR_W = $clog2(DEPTH);

   bq_entry_t        r_mem [DEPTH];
   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [CNT_W-1:0] r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_count == CNT_W'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_head    = r_mem[r_head];
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;

   // Storage carries no reset; validity is tracked by the count alone.
   always_ff @(posedge clock) begin
      if (w_do_push)
         r_mem[r_tail] <= i_push_data;
   end

   always_ff @(posedge clock) begin
      if (reset || i_flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push)
            r_tail <= r_tail + PTR_W'(1);
         if (w_do_pop)
            r_head <= r_head + PTR_W'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order resolution of predicted branches: trains the 2-bit counter, and on a
// mispredict redirects fetch and flushes every younger in-flight prediction.
module branch_resolve_queue
   import bp_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int IDX_W  = 6,
   parameter int ADDR_W = 32
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       pred_valid,
   output logic                       pred_ready,
   input  logic [IDX_W-1:0]           pred_idx,
   input  logic [1:0]                 pred_ctr,
   input  logic                       pred_taken,
   input  logic [ADDR_W-1:0]          pred_target,
   input  logic [ADDR_W-1:0]          pred_fallthru,
   input  logic                       res_valid,
   input  logic                       res_taken,
   input  logic [ADDR_W-1:0]          res_target,
   output logic                       upd_valid,
   output logic [IDX_W-1:0]           upd_idx,
   output logic [1:0]                 upd_ctr,
   output logic                       redirect_valid,
   output logic [ADDR_W-1:0]          redirect_pc,
   output logic                       res_error,
   output logic [$clog2(DEPTH+1)-1:0] occupancy
);

   brq_state_t        r_state;
   logic              r_upd_valid;
   logic [IDX_W-1:0]  r_upd_idx;
   ctr_t              r_upd_ctr;
   logic              r_redirect_valid;
   logic [ADDR_W-1:0] r_redirect_pc;
   logic              r_res_error;

   bq_entry_t w_push_entry;
   bq_entry_t w_head;
   logic      w_full;
   logic      w_empty;
   logic      w_run;
   logic      w_resolve;
   logic      w_target_miss;
   logic      w_mispred;
   logic      w_push;
   logic      w_pop;
   logic      w_res_err;

   assign w_push_entry = '{idx: pred_idx, ctr: ctr_t'(pred_ctr), taken: pred_taken,
                           target: pred_target, fallthru: pred_fallthru};

   assign w_run         = (r_state == RUN);
   assign pred_ready    = w_run && !w_full;
   assign w_resolve     = res_valid && w_run && !w_empty;
   assign w_res_err     = res_valid && w_run && w_empty;
   assign w_target_miss = res_taken && w_head.taken && (res_target != w_head.target);
   assign w_mispred     = w_resolve && ((res_taken != w_head.taken) || w_target_miss);
   // A push racing a mispredicting resolve is wrong-path and must not survive the flush.
   assign w_push        = pred_valid && pred_ready && !w_mispred;
   assign w_pop         = w_resolve && !w_mispred;

   bp_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock       (clock),
      .reset       (reset),
      .i_push      (w_push),
      .i_push_data (w_push_entry),
      .i_pop       (w_pop),
      .i_flush     (w_mispred),
      .o_head      (w_head),
      .o_full      (w_full),
      .o_empty     (w_empty),
      .o_count     (occupancy)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state          <= RUN;
         r_upd_valid      <= 1'b0;
         r_upd_idx        <= '0;
         r_upd_ctr        <= STRONG_NT;
         r_redirect_valid <= 1'b0;
         r_redirect_pc    <= '0;
         r_res_error      <= 1'b0;
      end else begin
         r_upd_valid      <= w_resolve;
         r_redirect_valid <= w_mispred;
         r_res_error      <= w_res_err;
         if (w_resolve) begin
            r_upd_idx <= w_head.idx;
            r_upd_ctr <= sat_update(w_head.ctr, res_taken);
         end
         if (w_mispred)
            r_redirect_pc <= res_taken ? res_target : w_head.fallthru;
         case (r_state)
            RUN:     if (w_mispred) r_state <= FLUSH;
            FLUSH:   r_state <= RUN;
            default: r_state <= RUN;
         endcase
      end
   end

   assign upd_valid      = r_upd_valid;
   assign upd_idx        = r_upd_idx;
   assign upd_ctr        = r_upd_ctr;
   assign redirect_valid = r_redirect_valid;
   assign redirect_pc    = r_redirect_pc;
   assign res_error      = r_res_error;

endmodule
